// File: rtl/centisecond_to_hms.sv
// Converts a 24-bit count of 10 ms ticks into hours/minutes/seconds/hundredths
// fields using an iterative shift-subtract divider (17 steps per conversion).
module centisecond_to_hms (
    input  logic        clockSignal,
    input  logic        resetN,
    input  logic        start,
    input  logic [23:0] tickCount,
    output logic        busy,
    output logic        done,
    output logic [4:0]  hoursOut,
    output logic [5:0]  minutesOut,
    output logic [5:0]  secondsOut,
    output logic [6:0]  centisecondsOut,
    output logic        overRange
);

    localparam int unsigned CNT_W  = 24;
    localparam int unsigned HRS_W  = 5;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned CS_W   = 7;
    localparam int unsigned IDX_W  = 3;

    localparam logic [CNT_W-1:0] MAX_COUNT   = CNT_W'(8639999);
    localparam logic [CNT_W-1:0] DIV_HOURS   = CNT_W'(360000);
    localparam logic [CNT_W-1:0] DIV_MINUTES = CNT_W'(6000);
    localparam logic [CNT_W-1:0] DIV_SECONDS = CNT_W'(100);

    localparam logic [IDX_W-1:0] HOURS_TOP = IDX_W'(4);
    localparam logic [IDX_W-1:0] SUB_TOP   = IDX_W'(5);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOURS   = 2'd1,
        MINUTES = 2'd2,
        SECONDS = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] rem;
    logic             ovr;
    logic [HRS_W-1:0] hrs_q;
    logic [MIN_W-1:0] min_q;
    logic [SEC_W-1:0] sec_q;
    logic [IDX_W-1:0] bit_idx;

    logic             accept_c;
    logic             last_bit_c;
    logic             finish_c;
    logic             take_c;
    logic [CNT_W-1:0] divisor_c;
    logic [CNT_W-1:0] shifted_c;
    logic [CNT_W-1:0] rem_step_c;
    logic [SEC_W-1:0] qmask_c;
    logic [CNT_W-1:0] clamped_c;
    logic             ovr_in_c;

    // State register
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)      state_next = HOURS;
            HOURS:   if (last_bit_c) state_next = MINUTES;
            MINUTES: if (last_bit_c) state_next = SECONDS;
            SECONDS: if (last_bit_c) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // FSM decode and one divider step
    always_comb begin
        accept_c   = 1'b0;
        divisor_c  = DIV_SECONDS;
        last_bit_c = (bit_idx == IDX_W'(0));
        finish_c   = 1'b0;
        unique case (state)
            IDLE:    accept_c  = start;
            HOURS:   divisor_c = DIV_HOURS;
            MINUTES: divisor_c = DIV_MINUTES;
            SECONDS: begin
                divisor_c = DIV_SECONDS;
                finish_c  = last_bit_c;
            end
            default: accept_c = 1'b0;
        endcase
        // Largest shifted divisor (360000<<4) still fits the 24-bit remainder
        shifted_c  = divisor_c << bit_idx;
        take_c     = (rem >= shifted_c);
        rem_step_c = take_c ? (rem - shifted_c) : rem;
        qmask_c    = take_c ? (SEC_W'(1) << bit_idx) : SEC_W'(0);
        ovr_in_c   = (tickCount > MAX_COUNT);
        clamped_c  = ovr_in_c ? MAX_COUNT : tickCount;
    end

    // Divider datapath and registered result outputs
    always_ff @(posedge clockSignal or negedge resetN) begin
        if (!resetN) begin
            rem             <= '0;
            ovr             <= 1'b0;
            hrs_q           <= '0;
            min_q           <= '0;
            sec_q           <= '0;
            bit_idx         <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            hoursOut        <= '0;
            minutesOut      <= '0;
            secondsOut      <= '0;
            centisecondsOut <= '0;
            overRange       <= 1'b0;
        end else begin
            done <= finish_c;
            if (accept_c) begin
                rem     <= clamped_c;
                ovr     <= ovr_in_c;
                hrs_q   <= '0;
                min_q   <= '0;
                sec_q   <= '0;
                bit_idx <= HOURS_TOP;
                busy    <= 1'b1;
            end else if (state != IDLE) begin
                rem <= rem_step_c;
                unique case (state)
                    HOURS:   hrs_q <= hrs_q | HRS_W'(qmask_c);
                    MINUTES: min_q <= min_q | qmask_c;
                    SECONDS: sec_q <= sec_q | qmask_c;
                    default: sec_q <= sec_q;
                endcase
                if (finish_c) begin
                    bit_idx <= '0;
                end else if (last_bit_c) begin
                    bit_idx <= SUB_TOP;
                end else begin
                    bit_idx <= bit_idx - IDX_W'(1);
                end
            end
            // Final SECONDS step: its quotient bit and remainder are folded in directly
            if (finish_c) begin
                busy            <= 1'b0;
                hoursOut        <= hrs_q;
                minutesOut      <= min_q;
                secondsOut      <= sec_q | qmask_c;
                centisecondsOut <= rem_step_c[CS_W-1:0];
                overRange       <= ovr;
            end
        end
    end

endmodule

// File: tb/tb_centisecond_to_hms.sv
// Directed and swept checks of the centisecond-to-H:M:S converter.
module tb_centisecond_to_hms;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [23:0] tick_count;
    logic        busy;
    logic        done;
    logic [4:0]  hours;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic [6:0]  centis;
    logic        over_range;

    int n_total = 0;
    int n_bad   = 0;

    centisecond_to_hms dut (
        .clockSignal     (clk),
        .resetN          (rst_n),
        .start           (start),
        .tickCount       (tick_count),
        .busy            (busy),
        .done            (done),
        .hoursOut        (hours),
        .minutesOut      (minutes),
        .secondsOut      (seconds),
        .centisecondsOut (centis),
        .overRange       (over_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int h, input int m, input int s, input int c, input bit o);
        return {7'd0, 5'(h), 6'(m), 6'(s), 7'(c), o};
    endfunction

    function automatic logic [31:0] res_now();
        return {7'd0, hours, minutes, seconds, centis, over_range};
    endfunction

    function automatic logic [31:0] ref_model(input logic [23:0] v);
        int unsigned x;
        bit o;
        o = (v > 24'd8639999);
        x = o ? 8639999 : int'(v);
        return pack(x / 360000, (x % 360000) / 6000, (x % 6000) / 100, x % 100, o);
    endfunction

    // One full conversion: latency, busy width, result and done width
    task automatic run_conv(input logic [23:0] val, input logic [31:0] exp, input string tag);
        int lat;
        int busy_cnt;
        bit seen;
        lat = 0;
        busy_cnt = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        tick_count = val;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tick_count = ~val;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                seen = 1'b1;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd17);
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd17);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, res_now(), exp);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dn;
        int d1;
        int d2;
        logic [31:0] cap;
        logic [23:0] v;

        rst_n = 1'b0;
        start = 1'b0;
        tick_count = 24'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", res_now(), 32'd0);
        rst_n = 1'b1;

        run_conv(24'd0,        pack(0, 0, 0, 0, 1'b0),     "zero");
        run_conv(24'd4523456,  pack(12, 33, 54, 56, 1'b0), "mid");
        run_conv(24'd8639999,  pack(23, 59, 59, 99, 1'b0), "max");
        run_conv(24'd16777215, pack(23, 59, 59, 99, 1'b1), "allones");
        run_conv(24'd8640000,  pack(23, 59, 59, 99, 1'b1), "max_plus1");
        run_conv(24'd6000,     pack(0, 1, 0, 0, 1'b0),     "one_min");

        // Extra start pulses while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        tick_count = 24'd360000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        d1 = 0;
        cap = '0;
        for (int e = 1; e <= 24; e++) begin
            start = (e == 3 || e == 10);
            tick_count = 24'($urandom);
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dn++;
                if (d1 == 0) begin
                    d1 = e;
                    cap = res_now();
                end
            end
        end
        start = 1'b0;
        chk("ignore_start_done_count", 32'(dn), 32'd1);
        chk("ignore_start_done_edge", 32'(d1), 32'd17);
        chk("ignore_start_result", cap, pack(1, 0, 0, 0, 1'b0));

        // Start held high across done: back-to-back conversions
        @(negedge clk);
        start = 1'b1;
        tick_count = 24'd4523456;
        @(posedge clk);
        @(negedge clk);
        d1 = 0;
        d2 = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (d1 == 0) d1 = e;
                else if (d2 == 0) d2 = e;
            end
        end
        start = 1'b0;
        chk("b2b_first_done", 32'(d1), 32'd17);
        chk("b2b_second_done", 32'(d2), 32'd35);
        dn = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dn++;
        end
        chk("b2b_drain_idle", 32'(busy), 32'd0);
        chk("b2b_result", res_now(), pack(12, 33, 54, 56, 1'b0));

        // Asynchronous reset mid-conversion
        @(negedge clk);
        start = 1'b1;
        tick_count = 24'd100;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", res_now(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        run_conv(24'd6099, pack(0, 1, 0, 99, 1'b0), "after_abort");

        // Sweep against div/mod reference
        for (int i = 0; i < 1000; i++) begin
            v = 24'($urandom_range(8639999, 0));
            run_conv(v, ref_model(v), "sweep");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/centisecond_to_hms.md
# centisecond_to_hms

Sequential converter sitting directly downstream of the timer/stopwatch core. It takes the core's 24-bit accumulated count of 10 ms ticks (100 Hz clock) and produces the hours / minutes / seconds / hundredths fields that drive the display. It uses shift-subtract division: 17 iterations, a start/done handshake and registered, held outputs. It uses no hardware dividers.

## Interface
- MAX_COUNT, 8639999, largest legal input (23:59:59.99); larger inputs are clamped to this value.
- clockSignal  input  1  system clock, 100 Hz nominal; all state changes on its rising edge.
- resetN  input  1  asynchronous, active-low reset.
- start  input  1  request a conversion; sampled only in IDLE.
- tickCount  input  24  count of 10 ms ticks to convert; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when results update.
- hoursOut  output  5  0..23.
- minutesOut  output  6  0..59.
- secondsOut  output  6  0..59.
- centisecondsOut  output  7  0..99.
- overRange  output  1  last converted input exceeded MAX_COUNT.

## Operation
- States: IDLE, HOURS, MINUTES, SECONDS. There is no separate DONE state.
- IDLE with start=1:
  - Latch rem = min(tickCount, MAX_COUNT) into a 24-bit register.
  - Latch ovr = (tickCount > MAX_COUNT).
  - Clear the quotient registers, set bitIdx=4, go to HOURS.
- HOURS (5 edges, bitIdx 4..0):
  - If rem >= 360000<<bitIdx: subtract it and set hours bit bitIdx.
  - After bitIdx=0, set bitIdx=5 and go to MINUTES.
- MINUTES (6 edges, bitIdx 5..0): same rule with divisor 6000. Then bitIdx=5, go to SECONDS.
- SECONDS (6 edges, bitIdx 5..0): same rule with divisor 100.
- On the bitIdx=0 edge of SECONDS:
  - Write hoursOut, minutesOut, secondsOut.
  - Write centisecondsOut = final remainder [6:0].
  - Write overRange = ovr, pulse done, return to IDLE.
- Width rules:
  - The largest shifted divisor is 360000<<4 = 5,760,000, so comparisons fit in 24 bits.
  - After HOURS the remainder is < 360000; after MINUTES < 6000; after SECONDS < 100.
  - Quotient widths therefore never overflow.
- start while busy (HOURS/MINUTES/SECONDS) is ignored. It is not queued.
- Outputs hold their last result between conversions. tickCount changes during busy have no effect.

## Timing
- Reset (resetN low, asynchronous): state=IDLE, and all of the following are 0:
  - busy, done, overRange
  - hoursOut, minutesOut, secondsOut, centisecondsOut
  - internal rem, quotients and bitIdx
- Reset applies immediately regardless of the clock.
- Accepting edge = edge 0:
  - busy rises after edge 0.
  - HOURS occupies edges 1-5, MINUTES 6-11, SECONDS 12-17.
  - Results and done update on edge 17; busy falls on edge 17.
  - Latency is 17 clocks from the accepting edge to valid outputs.
- done is high exactly one cycle (edge 17 to edge 18); busy and done are never high together.
- Back-to-back: start high during the done cycle is accepted on edge 18, since state is IDLE. Maximum throughput is one conversion per 18 clocks.
- Reset asserted mid-conversion aborts it: no done pulse, outputs forced to 0. After release the block is in IDLE and accepts start on the first edge.
- Boundaries:
  - tickCount = MAX_COUNT is legal; overRange=0.
  - tickCount = MAX_COUNT+1 (8640000) or above clamps to 23:59:59.99 with overRange=1.
  - tickCount = 0 gives all-zero fields.

## Test plan
- Reset, then start with tickCount=0 -> done on edge 17, outputs 00:00:00.00, overRange=0, busy high for exactly 17 cycles.
- tickCount=4523456 -> 12:33:54.56, overRange=0; tickCount changed to 0 during busy does not alter the result.
- tickCount=8639999 -> 23:59:59.99, overRange=0. Then tickCount=16777215 -> 23:59:59.99, overRange=1. Then 8640000 -> same result, overRange=1.
- start pulsed again at edges 3 and 10 of a conversion of 360000 -> only one done pulse, result 01:00:00.00. Then start held high across done -> second conversion accepted on edge 18, its done on edge 35.
- resetN pulsed low mid-conversion (edge 8, asynchronously between edges) of 100 -> outputs immediately 0, no done. Next start with 6099 -> 00:01:00.99.
- Randomized sweep of 1000 values in 0..MAX_COUNT against a reference div/mod model; verify latency 17 and done width 1 on every conversion.
